fu_seq_ctrl: RTL and testbench

- Self-test sequencer for the JTAG core functional unit, a 16-state FSM that consumes a 4-bit X vector on the falling clock edge.
- Accepts a program of (X, expected Y) pairs, resets the functional unit, then drives one X per cycle.
- Captures the unit's state output after each step, compares it with the expected value and stores it for readback.
- Sits between the JTAG data-register logic and the functional_unit instance.

---
 rtl/fu_seq_ctrl_pkg.sv | 18 +
 rtl/fu_seq_ctrl_if.sv | 10 +
 rtl/fu_seq_mem.sv | 26 ++
 rtl/fu_seq_ctrl.sv | 114 +++++++++++
 tb/tb_fu_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_seq_ctrl_pkg.sv
// Shared types and constants for the functional-unit self-test sequencer.
package fu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FU_RST = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  localparam logic [3:0] SEQ_IDLE_X = 4'b0000;

  function automatic int unsigned seq_aw(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fu_seq_ctrl_if.sv
// Program-load handshake between the JTAG data-register logic and the sequencer.
interface fu_seq_ctrl_if;
  logic       prog_valid;
  logic [3:0] prog_x;
  logic [3:0] prog_exp;
  logic       prog_ready;

  modport master (output prog_valid, prog_x, prog_exp, input prog_ready);
  modport slave  (input prog_valid, prog_x, prog_exp, output prog_ready);
endinterface

// File: rtl/fu_seq_mem.sv
// DEPTH x 12 register file: {x,exp} program fields and captured y, one write port, two async reads.
module fu_seq_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wbe,      // [0] writes {x,exp}, [1] writes y
  input  logic [11:0]   wdata,
  input  logic [AW-1:0] raddr_p,
  output logic [7:0]    rdata_p,
  input  logic [AW-1:0] raddr_r,
  output logic [3:0]    rdata_r
);

  logic [11:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wbe[0]) mem[waddr][11:4] <= wdata[11:4];
    if (wbe[1]) mem[waddr][3:0]  <= wdata[3:0];
  end

  assign rdata_p = mem[raddr_p][11:4];
  assign rdata_r = mem[raddr_r][3:0];

endmodule

// File: rtl/fu_seq_ctrl.sv
// Self-test sequencer: loads (X, expected Y) pairs, resets the functional unit,
// steps it one X per cycle and captures/compares its state output.
module fu_seq_ctrl
  import fu_seq_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = seq_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          TLR,
  input  logic          clr,
  fu_seq_ctrl_if.slave  pif,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   fail_cnt,
  output logic [AW-1:0] first_fail,
  output logic          fu_tlr,
  output logic [3:0]    fu_x,
  input  logic [3:0]    fu_y,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_y
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  seq_state_e    state;
  logic [AW:0]   cnt;
  logic [AW-1:0] pidx;
  logic [AW-1:0] cap_idx;
  logic [3:0]    exp_q;
  logic [7:0]    prog_rd;
  logic          idle_like, accept, cap_en, mismatch, last;

  assign idle_like      = (state == ST_IDLE) || (state == ST_DONE);
  assign pif.prog_ready = idle_like && (cnt != CNT_FULL) && !start && !clr;
  assign accept         = pif.prog_valid && pif.prog_ready;

  // exp is staged alongside x so one read port serves the present index;
  // exp_q therefore always belongs to the entry being captured.
  assign cap_en   = ((state == ST_RUN) && (pidx != '0)) || ((state == ST_DRAIN) && (cnt != '0));
  assign cap_idx  = (state == ST_DRAIN) ? (cnt[AW-1:0] - IDX_ONE) : (pidx - IDX_ONE);
  assign mismatch = cap_en && (fu_y != exp_q);
  assign last     = ({1'b0, pidx} == (cnt - CNT_ONE));

  fu_seq_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .waddr   (accept ? cnt[AW-1:0] : cap_idx),
    .wbe     ({cap_en, accept}),
    .wdata   ({pif.prog_x, pif.prog_exp, fu_y}),
    .raddr_p (pidx),
    .rdata_p (prog_rd),
    .raddr_r (rd_addr),
    .rdata_r (rd_y)
  );

  always_ff @(posedge clk) begin
    if (TLR) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pidx       <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
      fu_x       <= SEQ_IDLE_X;
      exp_q      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_FU_RST;
            fail_cnt   <= '0;
            first_fail <= '0;
            pidx       <= '0;
          end else if (clr) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (accept) begin
            cnt   <= cnt + CNT_ONE;
            state <= ST_IDLE;
          end
        end
        ST_FU_RST: begin
          fu_x  <= SEQ_IDLE_X;
          state <= (cnt != '0) ? ST_RUN : ST_DRAIN;
        end
        ST_RUN: begin
          fu_x  <= prog_rd[7:4];
          exp_q <= prog_rd[3:0];
          pidx  <= pidx + IDX_ONE;
          if (last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          fu_x  <= SEQ_IDLE_X;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase

      if (mismatch) begin
        if (fail_cnt != CNT_FULL) fail_cnt <= fail_cnt + CNT_ONE;
        if (fail_cnt == '0)       first_fail <= cap_idx;
      end
    end
  end

  assign busy   = (state == ST_FU_RST) || (state == ST_RUN) || (state == ST_DRAIN);
  assign done   = (state == ST_DONE);
  assign pass   = done && (fail_cnt == '0);
  assign fu_tlr = TLR || (state == ST_FU_RST);

endmodule

// File: tb/tb_fu_seq_ctrl.sv
// Scoreboard bench for fu_seq_ctrl with a behavioural functional-unit model.
module tb_fu_seq_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          TLR, clr, start;
  logic          busy, done, pass, fu_tlr;
  logic [AW:0]   fail_cnt;
  logic [AW-1:0] first_fail;
  logic [3:0]    fu_x, fu_y, rd_y;
  logic [AW-1:0] rd_addr;

  fu_seq_ctrl_if pif();

  fu_seq_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .TLR(TLR), .clr(clr), .pif(pif), .start(start),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .fu_tlr(fu_tlr), .fu_x(fu_x), .fu_y(fu_y),
    .rd_addr(rd_addr), .rd_y(rd_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External functional unit: 16-state machine stepping on the falling edge.
  function automatic logic [3:0] fu_next(input logic [3:0] s, input logic [3:0] x);
    logic [3:0] r;
    r = {s[2:0], s[3] ^ s[1]} ^ x;
    return r + 4'd3;
  endfunction

  logic [3:0] fu_s;
  always @(negedge clk) begin
    if (fu_tlr) fu_s <= 4'h0;
    else        fu_s <= fu_next(fu_s, fu_x);
  end
  assign fu_y = fu_s;

  typedef struct packed {
    int                    n;
    int                    start_cyc;
    logic                  pass;
    logic [AW:0]           fail;
    logic [AW-1:0]         first;
    logic [DEPTH-1:0][3:0] ys;
  } sb_t;

  sb_t        sb[$];
  logic [3:0] m_x[$];
  logic [3:0] m_e[$];
  int tests = 0, fails = 0, checked = 0, pushed = 0;
  logic [3:0] dx [4] = '{4'h2, 4'h2, 4'hE, 4'h9};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [3:0] x, input logic [3:0] e);
    bit exp_rdy;
    exp_rdy = (m_x.size() < DEPTH);
    pif.prog_valid = 1'b1; pif.prog_x = x; pif.prog_exp = e;
    @(negedge clk);
    chk("prog_ready", pif.prog_ready, exp_rdy);
    if (exp_rdy) begin m_x.push_back(x); m_e.push_back(e); end
    tick();
    pif.prog_valid = 1'b0;
  endtask

  task automatic clear_prog();
    clr = 1'b1; pif.prog_valid = 1'b1;
    @(negedge clk);
    chk("ready_during_clr", pif.prog_ready, 0);
    tick();
    clr = 1'b0; pif.prog_valid = 1'b0;
    m_x.delete(); m_e.delete();
  endtask

  // Expected response: FU is reset, sees one idle X, then each program X in turn.
  task automatic load_prog(input int n, input bit rnd, input int bad_idx, input int corrupt_pct);
    logic [3:0] s, x, e;
    s = fu_next(4'h0, 4'h0);
    for (int i = 0; i < n; i++) begin
      x = rnd ? 4'($urandom_range(0, 15)) : dx[i];
      s = fu_next(s, x);
      e = s;
      if (i == bad_idx || $urandom_range(0, 99) < corrupt_pct) e = s ^ 4'($urandom_range(1, 15));
      offer(x, e);
    end
  endtask

  task automatic run(input bit with_valid);
    sb_t        ex;
    logic [3:0] s;
    ex = '0;
    ex.n = m_x.size();
    s = fu_next(4'h0, 4'h0);
    for (int i = 0; i < ex.n; i++) begin
      s = fu_next(s, m_x[i]);
      ex.ys[i] = s;
      if (s != m_e[i]) begin
        if (ex.fail == 0) ex.first = AW'(i);
        if (ex.fail < DEPTH) ex.fail = ex.fail + 1'b1;
      end
    end
    ex.pass = (ex.fail == 0);
    ex.start_cyc = cyc + 1;
    sb.push_back(ex);
    pushed++;
    start = 1'b1;
    if (with_valid) begin pif.prog_valid = 1'b1; pif.prog_x = 4'h5; pif.prog_exp = 4'h5; end
    @(negedge clk);
    if (with_valid) chk("ready_vs_start", pif.prog_ready, 0);
    tick();
    start = 1'b0; pif.prog_valid = 1'b0;
  endtask

  task automatic wait_checked();
    for (int i = 0; i < 200 && checked < pushed; i++) @(posedge clk);
    chk("run_completed", checked, pushed);
    tick();
  endtask

  // Monitor: pops one expectation per rising done and checks it, including readback.
  initial begin
    sb_t ex;
    int  busy_n, tlr_n;
    bit  done_q;
    busy_n = 0; tlr_n = 0; done_q = 1'b0;
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (TLR === 1'b1) begin
        busy_n = 0; tlr_n = 0;
      end else begin
        if (busy === 1'b1)   busy_n++;
        if (fu_tlr === 1'b1) tlr_n++;
      end
      if (done === 1'b1 && !done_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ex = sb.pop_front();
          chk("latency", cyc - ex.start_cyc, ex.n + 2);
          chk("busy_cycles", busy_n, ex.n + 2);
          chk("fu_tlr_cycles", tlr_n, 1);
          chk("pass", pass, ex.pass);
          chk("fail_cnt", fail_cnt, ex.fail);
          chk("first_fail", first_fail, ex.first);
          chk("fu_x_done", fu_x, 0);
          for (int i = 0; i < ex.n; i++) begin
            rd_addr = AW'(i);
            #1;
            chk("rd_y", rd_y, ex.ys[i]);
          end
          checked++;
        end
        busy_n = 0; tlr_n = 0;
      end
      done_q = (done === 1'b1);
    end
  end

  initial begin
    TLR = 1'b1; clr = 1'b0; start = 1'b0;
    pif.prog_valid = 1'b0; pif.prog_x = '0; pif.prog_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fu_x", fu_x, 0);
    chk("rst_fu_tlr", fu_tlr, 1);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_first_fail", first_fail, 0);
    tick();
    TLR = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", pif.prog_ready, 1);
    chk("fu_tlr_idle", fu_tlr, 0);
    tick();

    // Directed program, all matching
    load_prog(4, 1'b0, -1, 0);
    run(1'b0);
    wait_checked();

    // Same X values with entry 2 wrong, then append an entry while in DONE
    clear_prog();
    load_prog(4, 1'b0, 2, 0);
    run(1'b0);
    wait_checked();
    offer(4'h7, 4'h0);
    @(negedge clk);
    chk("done_after_accept", done, 0);
    tick();
    run(1'b0);
    wait_checked();

    // clr while busy must not disturb the run or the program
    run(1'b0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_checked();
    run(1'b0);
    wait_checked();

    // Empty program
    clear_prog();
    run(1'b0);
    wait_checked();

    // Full buffer plus one extra offer, then start with a simultaneous prog_valid
    load_prog(DEPTH, 1'b1, -1, 20);
    offer(4'hA, 4'hA);
    run(1'b0);
    wait_checked();
    run(1'b1);
    wait_checked();

    // TLR during RUN at pidx=2 aborts with no done
    clear_prog();
    load_prog(5, 1'b1, -1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("busy_in_run", busy, 1);
    TLR = 1'b1;
    @(negedge clk);
    chk("fu_tlr_during_tlr", fu_tlr, 1);
    tick();
    TLR = 1'b0;
    m_x.delete(); m_e.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_fu_x", fu_x, 0);
    chk("abort_ready", pif.prog_ready, 1);
    run(1'b0);
    wait_checked();

    // Randomized programs
    for (int k = 0; k < 6; k++) begin
      clear_prog();
      load_prog($urandom_range(1, DEPTH), 1'b1, -1, 25);
      run(1'b0);
      wait_checked();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
